// File: rtl/axi_resp_pkg.sv
// Shared types and constants for the AXI memory responder: burst encodings,
// response codes, FSM state types and a burst legality helper.
package axi_resp_pkg;

    localparam int unsigned AXI_ADDR_WIDTH = 32;
    localparam int unsigned AXI_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10,
        RSVD  = 2'b11
    } burst_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic {R_IDLE, R_BURST} rd_state_e;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;

    // Only full-width FIXED and INCR bursts touch the RAM; anything else errors every beat.
    function automatic logic burst_bad(input logic [1:0] burst, input logic [2:0] size,
                                       input logic [2:0] word_size);
        return !((burst == FIXED) || (burst == INCR)) || (size != word_size);
    endfunction

endpackage

// File: rtl/axi_mem_responder_if.sv
// AXI4 read/write channel bundle between a DMA-side master and the memory responder.
interface axi_mem_responder_if #(
    parameter int unsigned ADDR_WIDTH = axi_resp_pkg::AXI_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = axi_resp_pkg::AXI_DATA_WIDTH
);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic [2:0]            arprot;
    logic [3:0]            arcache;
    logic                  arvalid;
    logic                  arready;

    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic [2:0]            awprot;
    logic [3:0]            awcache;
    logic                  awvalid;
    logic                  awready;

    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_W-1:0]     wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;

    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    modport master (
        output araddr, arlen, arsize, arburst, arprot, arcache, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready,
        output awaddr, awlen, awsize, awburst, awprot, awcache, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  araddr, arlen, arsize, arburst, arprot, arcache, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready,
        input  awaddr, awlen, awsize, awburst, awprot, awcache, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/axi_mem_responder_ram.sv
// Word RAM with one registered read port and one byte-enabled write port.
// A read and write of the same word on the same edge returns the old data.
module axi_mem_responder_ram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_WORDS  = 1024,
    localparam int unsigned AW        = $clog2(MEM_WORDS),
    localparam int unsigned STRB_W    = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [STRB_W-1:0]     wr_strb
);

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    // Byte-enabled write; contents are never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (wr_strb[b]) begin
                    mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    // Registered read; the output holds its value until the next enabled read.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 memory-mapped slave backed by a word RAM. Read (AR/R) and write (AW/W/B)
// paths run as independent FSMs sharing only the RAM.
module axi_mem_responder
    import axi_resp_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = AXI_ADDR_WIDTH,
    parameter int unsigned           DATA_WIDTH = AXI_DATA_WIDTH,
    parameter int unsigned           MEM_WORDS  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input logic          axi_aclk,
    input logic          axi_reset,
    axi_mem_responder_if.slave bus
);

    localparam int unsigned           STRB_W      = DATA_WIDTH / 8;
    localparam int unsigned           IDX_LSB     = $clog2(STRB_W);
    localparam int unsigned           RAM_AW      = $clog2(MEM_WORDS);
    localparam logic [2:0]            WORD_SIZE   = 3'(IDX_LSB);
    localparam logic [ADDR_WIDTH-1:0] MEM_WORDS_A = ADDR_WIDTH'(MEM_WORDS);

    // Word indices are kept full address width so an INCR run past the top never wraps.
    function automatic logic out_of_window(input logic below, input logic [ADDR_WIDTH-1:0] idx);
        return below || (idx >= MEM_WORDS_A);
    endfunction

    logic alive_q;

    logic                  ram_rd_en;
    logic [RAM_AW-1:0]     ram_rd_addr;
    logic [DATA_WIDTH-1:0] ram_rd_data;
    logic                  ram_wr_en;

    // ---------------- read path ----------------
    rd_state_e             rd_state_q, rd_state_d;
    logic [ADDR_WIDTH-1:0] rd_idx_q, rd_idx_d, ld_idx;
    logic                  rd_below_q, rd_below_d, ld_below;
    logic                  rd_bad_q, rd_bad_d, ld_bad;
    logic                  rd_fixed_q, rd_fixed_d;
    logic [7:0]            rd_len_q, rd_len_d;
    logic [7:0]            rd_cnt_q, rd_cnt_d;
    logic                  rlast_q, rlast_d;
    logic                  rerr_q, rerr_d;
    logic                  rd_load;
    logic                  ar_open;
    logic                  r_out;

    assign ar_open = (rd_state_q == R_IDLE) && alive_q && !axi_reset;
    assign r_out   = (rd_state_q == R_BURST) && !axi_reset;

    // Read next-state: each load presents one beat, from AR (beat 0) or from an R handshake.
    always_comb begin
        rd_state_d = rd_state_q;
        rd_idx_d   = rd_idx_q;
        rd_below_d = rd_below_q;
        rd_bad_d   = rd_bad_q;
        rd_fixed_d = rd_fixed_q;
        rd_len_d   = rd_len_q;
        rd_cnt_d   = rd_cnt_q;
        rlast_d    = rlast_q;
        rerr_d     = rerr_q;
        rd_load    = 1'b0;
        ld_idx     = rd_idx_q;
        ld_below   = rd_below_q;
        ld_bad     = rd_bad_q;
        unique case (rd_state_q)
            R_IDLE: begin
                if (bus.arvalid && ar_open) begin
                    rd_state_d = R_BURST;
                    rd_load    = 1'b1;
                    ld_idx     = (bus.araddr - BASE_ADDR) >> IDX_LSB;
                    ld_below   = bus.araddr < BASE_ADDR;
                    ld_bad     = burst_bad(bus.arburst, bus.arsize, WORD_SIZE);
                    rd_fixed_d = (bus.arburst == FIXED);
                    rd_len_d   = bus.arlen;
                    rd_cnt_d   = 8'd0;
                    rlast_d    = (bus.arlen == 8'd0);
                end
            end
            R_BURST: begin
                if (bus.rready) begin
                    if (rlast_q) begin
                        rd_state_d = R_IDLE;
                    end else begin
                        rd_load  = 1'b1;
                        ld_idx   = rd_fixed_q ? rd_idx_q : rd_idx_q + ADDR_WIDTH'(1);
                        rd_cnt_d = rd_cnt_q + 8'd1;
                        rlast_d  = ((rd_cnt_q + 8'd1) == rd_len_q);
                    end
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
        if (rd_load) begin
            rd_idx_d   = ld_idx;
            rd_below_d = ld_below;
            rd_bad_d   = ld_bad;
            rerr_d     = ld_bad || out_of_window(ld_below, ld_idx);
        end
    end

    assign ram_rd_en   = rd_load && !rerr_d;
    assign ram_rd_addr = ld_idx[RAM_AW-1:0];

    // Read state registers; reset abandons any burst in flight.
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            rd_state_q <= R_IDLE;
            rd_idx_q   <= '0;
            rd_below_q <= 1'b0;
            rd_bad_q   <= 1'b0;
            rd_fixed_q <= 1'b0;
            rd_len_q   <= 8'd0;
            rd_cnt_q   <= 8'd0;
            rlast_q    <= 1'b0;
            rerr_q     <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_idx_q   <= rd_idx_d;
            rd_below_q <= rd_below_d;
            rd_bad_q   <= rd_bad_d;
            rd_fixed_q <= rd_fixed_d;
            rd_len_q   <= rd_len_d;
            rd_cnt_q   <= rd_cnt_d;
            rlast_q    <= rlast_d;
            rerr_q     <= rerr_d;
        end
    end

    assign bus.arready = ar_open;
    assign bus.rvalid  = r_out;
    assign bus.rdata   = (r_out && !rerr_q) ? ram_rd_data : '0;
    assign bus.rresp   = (r_out && rerr_q) ? SLVERR : OKAY;
    assign bus.rlast   = r_out && rlast_q;

    // ---------------- write path ----------------
    wr_state_e             wr_state_q, wr_state_d;
    logic [ADDR_WIDTH-1:0] wr_idx_q, wr_idx_d;
    logic                  wr_below_q, wr_below_d;
    logic                  wr_bad_q, wr_bad_d;
    logic                  wr_fixed_q, wr_fixed_d;
    logic [7:0]            wr_len_q, wr_len_d;
    logic [8:0]            wr_cnt_q, wr_cnt_d;
    logic                  wr_err_q, wr_err_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  beat_extra;
    logic                  beat_err;
    logic                  aw_open;

    assign aw_open = (wr_state_q == W_IDLE) && alive_q && !axi_reset;

    // Write next-state: beats past awlen+1 are dropped until wlast closes the burst.
    always_comb begin
        wr_state_d = wr_state_q;
        wr_idx_d   = wr_idx_q;
        wr_below_d = wr_below_q;
        wr_bad_d   = wr_bad_q;
        wr_fixed_d = wr_fixed_q;
        wr_len_d   = wr_len_q;
        wr_cnt_d   = wr_cnt_q;
        wr_err_d   = wr_err_q;
        bresp_d    = bresp_q;
        ram_wr_en  = 1'b0;
        beat_extra = wr_cnt_q > {1'b0, wr_len_q};
        beat_err   = wr_bad_q || out_of_window(wr_below_q, wr_idx_q);
        unique case (wr_state_q)
            W_IDLE: begin
                if (bus.awvalid && aw_open) begin
                    wr_state_d = W_DATA;
                    wr_idx_d   = (bus.awaddr - BASE_ADDR) >> IDX_LSB;
                    wr_below_d = bus.awaddr < BASE_ADDR;
                    wr_bad_d   = burst_bad(bus.awburst, bus.awsize, WORD_SIZE);
                    wr_fixed_d = (bus.awburst == FIXED);
                    wr_len_d   = bus.awlen;
                    wr_cnt_d   = 9'd0;
                    wr_err_d   = 1'b0;
                end
            end
            W_DATA: begin
                if (bus.wvalid) begin
                    ram_wr_en = !beat_extra && !beat_err;
                    if (bus.wlast) begin
                        wr_state_d = W_RESP;
                        bresp_d    = (wr_err_q || (beat_err && !beat_extra) ||
                                      (wr_cnt_q != {1'b0, wr_len_q})) ? SLVERR : OKAY;
                    end else begin
                        if (!beat_extra) begin
                            wr_err_d = wr_err_q || beat_err;
                            wr_idx_d = wr_fixed_q ? wr_idx_q : wr_idx_q + ADDR_WIDTH'(1);
                        end
                        if (wr_cnt_q != '1) begin
                            wr_cnt_d = wr_cnt_q + 9'd1;
                        end
                    end
                end
            end
            W_RESP: begin
                if (bus.bready) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // Write state registers plus the one-cycle post-reset hold on the address readies.
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            wr_state_q <= W_IDLE;
            wr_idx_q   <= '0;
            wr_below_q <= 1'b0;
            wr_bad_q   <= 1'b0;
            wr_fixed_q <= 1'b0;
            wr_len_q   <= 8'd0;
            wr_cnt_q   <= 9'd0;
            wr_err_q   <= 1'b0;
            bresp_q    <= OKAY;
            alive_q    <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_idx_q   <= wr_idx_d;
            wr_below_q <= wr_below_d;
            wr_bad_q   <= wr_bad_d;
            wr_fixed_q <= wr_fixed_d;
            wr_len_q   <= wr_len_d;
            wr_cnt_q   <= wr_cnt_d;
            wr_err_q   <= wr_err_d;
            bresp_q    <= bresp_d;
            alive_q    <= 1'b1;
        end
    end

    assign bus.awready = aw_open;
    assign bus.wready  = (wr_state_q == W_DATA) && !axi_reset;
    assign bus.bvalid  = (wr_state_q == W_RESP) && !axi_reset;
    assign bus.bresp   = ((wr_state_q == W_RESP) && !axi_reset) ? bresp_q : OKAY;

    logic unused_sideband;
    assign unused_sideband = ^{bus.arprot, bus.arcache, bus.awprot, bus.awcache};

    axi_mem_responder_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_WORDS  (MEM_WORDS)
    ) u_ram (
        .clk     (axi_aclk),
        .rd_en   (ram_rd_en),
        .rd_addr (ram_rd_addr),
        .rd_data (ram_rd_data),
        .wr_en   (ram_wr_en),
        .wr_addr (wr_idx_q[RAM_AW-1:0]),
        .wr_data (bus.wdata),
        .wr_strb (bus.wstrb)
    );

endmodule
